// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction width, NOP encoding,
// brbus field positions and the prefetch queue entry.
package cpu_pkg;

  localparam int INST_W = 16;
  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

  localparam int BRBUS_VALID_BIT  = 17;
  localparam int BRBUS_TAKEN_BIT  = 16;
  localparam int BRBUS_OFFSET_MSB = 15;

  typedef struct packed {
    logic [15:0]       pc;
    logic [INST_W-1:0] inst;
  } inst_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_fifo.sv
// ipq_fifo: DEPTH-entry queue of {pc, inst} with count.
// Ports: clock, reset, push_i, pop_i, flush_i, wdata_i,
//        head_o, full_o, empty_o. Flush beats push/pop.
module ipq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  inst_entry_t wdata_i,
  output inst_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  inst_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue feeding decode via brbus.
// Ports: clock, reset, brbus, rom_addr, rom_data, inst,
//   inst_valid, inst_pc; flush_count if IPQ_FLUSH_STATS_EN.
module inst_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] brbus,
  output logic [11:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic [15:0] inst_pc
`ifdef IPQ_FLUSH_STATS_EN
  ,
  output logic [15:0] flush_count
`endif
);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            push, pop, flush;
  logic            full, empty;
  logic [15:0]     target;
  inst_entry_t     wdata, head;

  assign flush = brbus[BRBUS_TAKEN_BIT] && !empty;
  assign pop   = brbus[BRBUS_VALID_BIT] && !empty
              && !brbus[BRBUS_TAKEN_BIT];
  // Pop frees a slot this edge, so a full queue still fetches.
  assign push  = (!full || pop) && !flush;

  // Branch target is relative to the head (the branch itself).
  assign target = (head.pc + brbus[BRBUS_OFFSET_MSB:0])
                & 16'hFFFE;

  assign wdata.pc   = 16'(fetch_pc_q);
  assign wdata.inst = rom_data;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (flush)     fetch_pc_d = PC_W'(target);
    else if (push) fetch_pc_d = fetch_pc_q + PC_W'(2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) fetch_pc_q <= '0;
    else       fetch_pc_q <= fetch_pc_d;
  end

  ipq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wdata),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rom_addr   = fetch_pc_q[12:1];
  assign inst_valid = !empty;
  assign inst       = empty ? NOP_INST : head.inst;
  assign inst_pc    = empty ? 16'h0000 : head.pc;

`ifdef IPQ_FLUSH_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush && flush_cnt_q != 16'hFFFF)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) flush_cnt_q <= '0;
    else       flush_cnt_q <= flush_cnt_d;
  end

  assign flush_count = flush_cnt_q;
`endif

endmodule
